// File: rtl/ca_row_scheduler.sv
// Write/read sequencer for the four-bank CA digit register file: digits fill rows of a circular
// row buffer, rows are issued to the online-arithmetic pipeline. Optional error flag: CA_ROW_SCHED_ERR_EN.
module ca_row_scheduler #(
  parameter int RAM_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 12
) (
  input  logic                      clk,
  input  logic                      asyn_reset,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      op_rows,
  input  logic                      dig_valid,
  output logic                      dig_ready,
  output logic                      wr_enable,
  output logic                      enable_all,
  output logic [RAM_ADDR_WIDTH+1:0] master_cnt,
  input  logic                      rd_req,
  output logic                      rd_ready,
  output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
  output logic                      rd_data_valid,
  output logic [RAM_ADDR_WIDTH-1:0] comp_cycle,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int AW = RAM_ADDR_WIDTH;
  localparam int PW = RAM_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic [PW-1:0]         wr_row_reg, rd_row_reg;
  logic [1:0]            digit_sel_reg;
  logic [LEN_WIDTH-1:0]  rows_written_reg, op_rows_reg;
  logic                  rd_data_valid_reg;
  logic [AW-1:0]         comp_cycle_reg;

  logic [PW-1:0] avail;
  logic          full, active, wr_fire, row_done, last_row, issue, start_ok;

  // Pointers carry one extra bit so a full buffer is distinguishable from an empty one.
  assign avail    = wr_row_reg - rd_row_reg;
  assign full     = (avail == DEPTH);
  assign active   = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign start_ok = (state_reg == S_IDLE) && start;

  assign dig_ready = (state_reg == S_RUN) && !full && (rows_written_reg < op_rows_reg);
  assign wr_fire   = dig_valid && dig_ready;
  assign row_done  = wr_fire && (digit_sel_reg == 2'd3);
  assign last_row  = (rows_written_reg == op_rows_reg - LEN_WIDTH'(1));
  assign rd_ready  = active && (avail != '0);
  assign issue     = rd_req && rd_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = (op_rows == '0) ? S_DONE : S_RUN;
      S_RUN:   if (row_done && last_row) state_next = S_DRAIN;
      // Final row's data is on the bus and nothing is left to issue.
      S_DRAIN: if (rd_data_valid_reg && (avail == '0)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_reg         <= S_IDLE;
      wr_row_reg        <= '0;
      rd_row_reg        <= '0;
      digit_sel_reg     <= '0;
      rows_written_reg  <= '0;
      op_rows_reg       <= '0;
      rd_data_valid_reg <= 1'b0;
      comp_cycle_reg    <= '0;
    end else begin
      state_reg         <= state_next;
      rd_data_valid_reg <= issue;
      if (start_ok) begin
        wr_row_reg       <= '0;
        rd_row_reg       <= '0;
        digit_sel_reg    <= '0;
        rows_written_reg <= '0;
        comp_cycle_reg   <= '0;
        op_rows_reg      <= op_rows;
      end else begin
        if (wr_fire) digit_sel_reg <= digit_sel_reg + 2'd1;
        if (row_done) begin
          wr_row_reg       <= wr_row_reg + PW'(1);
          rows_written_reg <= rows_written_reg + LEN_WIDTH'(1);
        end
        if (issue) begin
          rd_row_reg     <= rd_row_reg + PW'(1);
          comp_cycle_reg <= comp_cycle_reg + AW'(1);
        end
      end
    end
  end

  assign wr_enable     = wr_fire;
  assign enable_all    = active;
  assign master_cnt    = {wr_row_reg[AW-1:0], digit_sel_reg};
  assign rd_addr       = rd_row_reg[AW-1:0];
  assign rd_data_valid = rd_data_valid_reg;
  assign comp_cycle    = comp_cycle_reg;
  assign busy          = (state_reg != S_IDLE);
  assign done          = (state_reg == S_DONE);

`ifdef CA_ROW_SCHED_ERR_EN
  logic err_reg;
  logic err_set;

  // A request in DRAIN with nothing buffered and nothing in flight can never be served.
  assign err_set = (dig_valid && ((state_reg == S_IDLE) || (state_reg == S_DONE)))
                || (start && busy)
                || (rd_req && (state_reg == S_DRAIN) && (avail == '0) && !rd_data_valid_reg);

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)   err_reg <= 1'b0;
    else if (err_set) err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule
